multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  7  instruction[6:0] from the instruction register; sampled in DECODE and MEMADDR only.
REQ-005 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-006 ALUOp  output  2  to ALU control: 00 add, 01 branch compare, 10 R-type decode.
REQ-007 ALUSrcA  output  1  ALU A operand select: 0 PC, 1 rs1.
REQ-008 ALUSrcB  output  2  ALU B operand select: 00 rs2, 01 constant 4, 10 immediate, 11 branch offset.
REQ-009 IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite, MemtoReg, PCSource  output  1 each  datapath strobes and selects.
REQ-010 instr_done  output  1  one-cycle pulse on the last cycle of each completed instruction.
REQ-011 illegal  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-012 state  output  4  current state encoding, for debug.

Function
REQ-013 State encoding SHALL be FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8.
REQ-014 Unused codes 9-15 SHALL transition to FETCH on the next edge, with all strobes 0.
REQ-015 Outputs SHALL be combinational from state, plus mem_ready where stated. Any output not listed for a state SHALL be 0.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
- IRWrite=PCWrite=mem_ready.
- Next state: DECODE if mem_ready, else remain in FETCH.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- Next state by opcode: 0000011 or 0100011 -> MEMADDR; 0110011 -> EXEC; 1100011 -> BRANCH.
- Any other opcode -> FETCH with illegal=1 and instr_done=0.
REQ-018 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- Next state: MEMRD if opcode=0000011, else MEMWR.
REQ-019 MEMRD: MemRead=1, IorD=1.
- Next state: MEMWB if mem_ready, else remain in MEMRD.
REQ-020 MEMWB: RegWrite=1, MemtoReg=1, instr_done=1; next state FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; instr_done=mem_ready.
- Next state: FETCH if mem_ready, else remain in MEMWR.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state RWB.
REQ-023 RWB: RegWrite=1, MemtoReg=0, instr_done=1; next state FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1, instr_done=1; next state FETCH.
REQ-025 Minimum latency with mem_ready held high: LW 5 cycles, SW 4, R-type 4, branch 3. Each low mem_ready cycle in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-026 MemRead and MemWrite SHALL never both be 1. RegWrite SHALL never be 1 in FETCH or DECODE.

Reset
REQ-027 rst=1 SHALL force state=FETCH immediately, without waiting for a clock edge.
REQ-028 While rst=1, IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite, instr_done and illegal SHALL be 0, regardless of mem_ready.
REQ-029 Reset asserted in any state, including a memory wait, SHALL abandon the instruction with no strobe pulse. First FETCH access starts on the first edge after rst deasserts.

Verification
REQ-030 LW (opcode 0000011), mem_ready=1 throughout -> states 0,1,2,3,4,0. RegWrite=MemtoReg=1 and instr_done=1 only in state 4.
REQ-031 SW (0100011), mem_ready low for 2 cycles in MEMWR -> state 5 held 3 cycles. MemWrite=1 for all 3; instr_done=1 on the 3rd only.
REQ-032 R-type (0110011) -> ALUOp=10 in state 6, RegWrite=1 with MemtoReg=0 in state 7, 4 cycles total. Branch (1100011) -> ALUOp=01 and PCWriteCond=1 in state 8, 3 cycles total.
REQ-033 opcode 1111111 in DECODE -> illegal=1 for one cycle, next state 0, no RegWrite/MemWrite/instr_done.
REQ-034 rst pulsed asynchronously mid-MEMRD with mem_ready=0 -> state=0 before the next edge, all strobes 0. After release, FETCH with MemRead=1.
REQ-035 Force state=12 -> next edge state=0, no strobes asserted.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for a multicycle load/store/R-type/branch datapath
//
// Ports:
//   clk, rst          single clock, asynchronous active-high reset
//   opcode[6:0]       instruction opcode, looked at in DECODE and MEMADDR only
//   mem_ready         memory handshake; an access completes in the cycle it is high
//   ALUOp[1:0]        00 add, 01 branch compare, 10 R-type decode
//   ALUSrcA           0 PC, 1 rs1
//   ALUSrcB[1:0]      00 rs2, 01 constant 4, 10 immediate, 11 branch offset
//   IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond,
//   RegWrite, MemtoReg, PCSource   datapath strobes and selects
//   instr_done        pulse on the last cycle of a completed instruction
//   illegal           pulse when DECODE sees an unsupported opcode
//   state[3:0]        current state, for debug
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       PCSource,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Held as a plain 4-bit vector so the unused codes 9-15 are representable
  // and recover cleanly through the default branch.
  logic [3:0] state_r;

  assign state = state_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      case (state_r)
        FETCH:   if (mem_ready) state_r <= DECODE;
        DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_r <= MEMADDR;
            OP_RTYPE:          state_r <= EXEC;
            OP_BRANCH:         state_r <= BRANCH;
            default:           state_r <= FETCH;
          endcase
        end
        MEMADDR: state_r <= (opcode == OP_LOAD) ? MEMRD : MEMWR;
        MEMRD:   if (mem_ready) state_r <= MEMWB;
        MEMWB:   state_r <= FETCH;
        MEMWR:   if (mem_ready) state_r <= FETCH;
        EXEC:    state_r <= RWB;
        RWB:     state_r <= FETCH;
        BRANCH:  state_r <= FETCH;
        default: state_r <= FETCH;
      endcase
    end
  end

  always_comb begin
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;

    case (state_r)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        if (opcode != OP_LOAD && opcode != OP_STORE &&
            opcode != OP_RTYPE && opcode != OP_BRANCH)
          illegal = 1'b1;
      end
      MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        instr_done  = 1'b1;
      end
      default: ;
    endcase

    // While reset is held the state already reads FETCH, but no strobe may
    // fire even though FETCH would otherwise follow mem_ready.
    if (rst) begin
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed vector bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b1;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond;
  logic       RegWrite, MemtoReg, PCSource, instr_done, illegal;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .PCSource(PCSource), .instr_done(instr_done),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Field order: ALUOp(2) SrcA SrcB(2) IorD MemRead MemWrite IRWrite PCWrite
  //              PCWriteCond RegWrite MemtoReg PCSource instr_done illegal
  logic [15:0] obs;
  assign obs = {ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                PCWriteCond, RegWrite, MemtoReg, PCSource, instr_done, illegal};

  localparam logic [15:0] O_RST   = 16'b00_0_01_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_F1    = 16'b00_0_01_0_1_0_1_1_0_0_0_0_0_0;
  localparam logic [15:0] O_F0    = 16'b00_0_01_0_1_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_DEC   = 16'b00_0_11_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_DECIL = 16'b00_0_11_0_0_0_0_0_0_0_0_0_0_1;
  localparam logic [15:0] O_MA    = 16'b00_1_10_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_MRD   = 16'b00_0_00_1_1_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_MWB   = 16'b00_0_00_0_0_0_0_0_0_1_1_0_1_0;
  localparam logic [15:0] O_MWR0  = 16'b00_0_00_1_0_1_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_MWR1  = 16'b00_0_00_1_0_1_0_0_0_0_0_0_1_0;
  localparam logic [15:0] O_EXEC  = 16'b10_1_00_0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] O_RWB   = 16'b00_0_00_0_0_0_0_0_0_1_0_0_1_0;
  localparam logic [15:0] O_BR    = 16'b01_1_00_0_0_0_0_0_1_0_0_1_1_0;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] IL = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] out;
  } vec_t;

  vec_t tbl[40];
  int   nvec = 0;
  int   total = 0;
  int   bad = 0;

  task automatic add(input logic [6:0] op, input logic mr, input logic [3:0] st,
                     input logic [15:0] out);
    tbl[nvec].op  = op;
    tbl[nvec].mr  = mr;
    tbl[nvec].st  = st;
    tbl[nvec].out = out;
    nvec++;
  endtask

  task automatic chk(input string name, input logic [3:0] exp_st, input logic [15:0] exp_out);
    total++;
    if (state !== exp_st || obs !== exp_out) begin
      bad++;
      $display("FAIL %s: state=%0d outs=%b, want state=%0d outs=%b",
               name, state, obs, exp_st, exp_out);
    end
  endtask

  initial begin
    // LW, mem_ready high throughout: 0,1,2,3,4
    add(LW, 1, 0, O_F1); add(LW, 1, 1, O_DEC); add(LW, 1, 2, O_MA);
    add(LW, 1, 3, O_MRD); add(LW, 1, 4, O_MWB);
    // SW with one FETCH wait and two MEMWR waits
    add(SW, 0, 0, O_F0); add(SW, 1, 0, O_F1); add(SW, 1, 1, O_DEC); add(SW, 1, 2, O_MA);
    add(SW, 0, 5, O_MWR0); add(SW, 0, 5, O_MWR0); add(SW, 1, 5, O_MWR1);
    // R-type
    add(RT, 1, 0, O_F1); add(RT, 1, 1, O_DEC); add(RT, 1, 6, O_EXEC); add(RT, 1, 7, O_RWB);
    // branch
    add(BR, 1, 0, O_F1); add(BR, 1, 1, O_DEC); add(BR, 1, 8, O_BR);
    // illegal opcode drops back to FETCH
    add(IL, 1, 0, O_F1); add(IL, 1, 1, O_DECIL);
    // LW with one MEMRD wait
    add(LW, 1, 0, O_F1); add(LW, 1, 1, O_DEC); add(LW, 1, 2, O_MA);
    add(LW, 0, 3, O_MRD); add(LW, 1, 3, O_MRD); add(LW, 1, 4, O_MWB);
    // lands back in FETCH
    add(LW, 0, 0, O_F0);

    // reset held across a clock edge with mem_ready high
    @(negedge clk);
    #1 chk("reset_state", 4'd0, O_RST);
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      opcode    = tbl[i].op;
      mem_ready = tbl[i].mr;
      #1 chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].out);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a MEMRD wait
    opcode = LW; mem_ready = 1'b1;
    #1 chk("mid_fetch", 4'd0, O_F1);
    @(negedge clk);
    #1 chk("mid_dec", 4'd1, O_DEC);
    @(negedge clk);
    #1 chk("mid_ma", 4'd2, O_MA);
    @(negedge clk);
    mem_ready = 1'b0;
    #1 chk("mid_memrd_wait", 4'd3, O_MRD);
    #2 rst = 1'b1;
    #1 chk("async_rst_now", 4'd0, O_RST);
    mem_ready = 1'b1;
    #1 chk("rst_gates_mr", 4'd0, O_RST);
    @(negedge clk);
    #1 chk("rst_held_edge", 4'd0, O_RST);
    rst = 1'b0;
    #1 chk("post_rst_fetch", 4'd0, O_F1);
    @(negedge clk);
    #1 chk("post_rst_dec", 4'd1, O_DEC);

    // unused state code recovers to FETCH with nothing asserted
    force dut.state_r = 4'd12;
    #1 chk("unused_state", 4'd12, 16'd0);
    mem_ready = 1'b0;
    #1 release dut.state_r;
    @(posedge clk);
    #1 chk("unused_recover", 4'd0, O_F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
